// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches ROM words, decodes the opcode and
// hands CALC operands to the compute core over a valid/ready handshake.
module instruction_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  instruction,
  output logic              calc_valid,
  output logic [11:0]       calc_operand,
  input  logic              calc_ready,
  input  logic              calc_done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALTED,
    S_ERROR
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CALC = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             state;
  state_t             next;
  logic [ADDR_W-1:0]  pc;
  logic [WIDTH-1:0]   ir;
  logic [3:0]         opcode;
  logic               is_nop;
  logic               is_calc;
  logic               is_halt;
  logic               last;
  logic               stopped;

  assign opcode  = ir[WIDTH-1 -: 4];
  assign is_nop  = opcode == OP_NOP;
  assign is_calc = opcode == OP_CALC;
  assign is_halt = opcode == OP_HALT;
  assign last    = pc == ADDR_W'(DEPTH - 1);
  assign stopped = state == S_IDLE
                || state == S_HALTED
                || state == S_ERROR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) next = S_FETCH;
      end
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_calc: next = S_ISSUE;
          is_nop:  next = last ? S_ERROR : S_FETCH;
          is_halt: next = S_HALTED;
          default: next = S_ERROR;
        endcase
      end
      S_ISSUE: begin
        if (calc_ready) next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // pc never wraps: running off the ROM end is a fault
        if (calc_done) next = last ? S_ERROR : S_FETCH;
      end
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    calc_valid = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: ;
      S_HALTED: halted = 1'b1;
      S_ERROR: begin
        halted = 1'b1;
        error  = 1'b1;
      end
      S_ISSUE: begin
        busy       = 1'b1;
        calc_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (stopped && start) begin
        pc      <= '0;
        retired <= '0;
      end
      if (state == S_FETCH) ir <= instruction;
      if (state == S_DECODE && is_nop && !last) pc <= pc + 1'b1;
      if (state == S_WAIT_DONE && calc_done) begin
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
        if (!last) pc <= pc + 1'b1;
      end
    end
  end

  assign addr         = pc;
  assign calc_operand = ir[11:0];

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode controller that sits directly downstream of the firmware instruction ROM. It drives the ROM address, latches each returned 16-bit instruction, decodes the 4-bit opcode, and hands CALC commands to the compute core over a valid/ready handshake. It then waits for the core's completion pulse and advances the program counter until a HALT instruction or an illegal opcode stops execution.

## Interface
- `WIDTH`, default 16: instruction width. Opcode is `[WIDTH-1:WIDTH-4]`; operand is `[11:0]`.
- `DEPTH`, default 64: ROM depth. `ADDR_W = $clog2(DEPTH)` is derived, not overridable.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin execution at address 0; sampled only in IDLE, HALTED or ERROR.
- `addr`  out  ADDR_W: ROM address (equals pc).
- `instruction`  in  WIDTH: ROM data, combinational from `addr`.
- `calc_valid`  out  1: CALC command offered to the compute core.
- `calc_operand`  out  12: operand of the offered CALC.
- `calc_ready`  in  1: core accepts the command.
- `calc_done`  in  1: single-cycle pulse when the core finishes the accepted command.
- `busy`  out  1: high in every state except IDLE, HALTED and ERROR.
- `halted`  out  1: high in HALTED and ERROR.
- `error`  out  1: high in ERROR only.
- `retired`  out  16: count of completed CALC instructions since the last start.

## Operation
- Opcodes: NOP=0x0, CALC=0x3, HALT=0xF. All others are illegal.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, HALTED, ERROR.
- IDLE: on `start`, set pc=0, clear `retired`, go to FETCH.
- FETCH: latch IR <= `instruction` (ROM addressed by pc), go to DECODE.
- DECODE:
  - CALC: go to ISSUE.
  - NOP: pc+1, go to FETCH.
  - HALT: go to HALTED; pc holds at the HALT address.
  - Illegal opcode: go to ERROR.
- ISSUE: `calc_valid`=1 and `calc_operand`=IR[11:0]. Both are stable until `calc_ready`. On `calc_valid && calc_ready`, go to WAIT_DONE.
- WAIT_DONE: on `calc_done`, `retired`+1 (saturating at 0xFFFF), pc+1, go to FETCH.
- `calc_done` is ignored outside WAIT_DONE.
- Operand 0 is issued unchanged; the block does no operand checking.
- End of ROM: advancing pc from DEPTH-1 without a HALT goes to ERROR. pc does not wrap.
- HALTED / ERROR: outputs hold. `start` restarts from pc=0, clears `error` and `retired`, and goes to FETCH.
- `start` while `busy` is ignored.

## Timing
- Reset values: pc/`addr`=0, IR=0, state=IDLE, `calc_valid`=0, `calc_operand`=0, `busy`=0, `halted`=0, `error`=0, `retired`=0.
- Reset asserted mid-operation: all outputs go to reset values immediately (async). `calc_valid` drops without a handshake; a subsequent `calc_done` is ignored.
- All outputs are registered or decoded from state/IR only. There is no combinational path from `calc_ready`/`calc_done` to outputs.
- Latency, `start` sampled at edge N:
  - FETCH in cycle N+1, DECODE in N+2.
  - ISSUE (`calc_valid`=1) from N+3.
  - With `calc_ready`=1 at N+3, WAIT_DONE from N+4.
- `calc_done` at edge M gives FETCH of the next pc in M+1.
- NOP costs 2 cycles. HALT reaches HALTED 2 cycles after entering FETCH.
- `calc_valid` is asserted for at least 1 cycle and deasserts the cycle after acceptance.

## Test plan
- ROM {0x3003, 0xF000}, `calc_ready`=1, `calc_done` pulsed 2 cycles after acceptance, `start` at edge 0:
  - `calc_valid` high in cycle 3 only, with `calc_operand`=3.
  - `retired`=1; HALTED with `addr`=1; `busy`=0, `halted`=1, `error`=0.
- Backpressure: ROM {0x3005, 0xF000}, `calc_ready` low for 5 cycles:
  - `calc_valid` held high 6 cycles with `calc_operand`=5 constant.
  - Exactly one acceptance; `retired`=1.
- ROM {0x0000, 0x0000, 0x3001, 0xF000}:
  - Two NOPs, then one CALC issued with `addr`=2.
  - HALTED at `addr`=3 after the done pulse.
- ROM {0x5123}:
  - ERROR 2 cycles after FETCH; `error`=1, `halted`=1, `calc_valid` never asserted.
  - Then `start` clears `error` and refetches `addr` 0.
- Reset during WAIT_DONE, then `calc_done` pulsed:
  - All outputs return to reset values immediately; `retired` stays 0; state stays IDLE.
- Extra `calc_done` pulses in ISSUE/IDLE and `start` pulses while `busy`:
  - `retired` and pc unchanged by the stray pulses.
- ROM with 64 NOPs (no HALT):
  - ERROR after `addr`=63 decodes; `addr` never wraps to 0.
